// File: rtl/fb_scanout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_scanout_pkg
// Description : Shared definitions for the framebuffer scanout block.
//               - Default 640x480@60 timing: active, porch and sync widths
//                 plus the resulting line and frame totals.
//               - Framebuffer address width.
//               - Colour constants.
//               - The control bundle (sync, blank, frame_start) that rides
//                 the delay line next to the pixel data.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_scanout_pkg;

    localparam int c_H_ACTIVE  = 640;
    localparam int c_H_FP      = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BP      = 48;
    localparam int c_H_TOTAL   = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;   // 800

    localparam int c_V_ACTIVE  = 480;
    localparam int c_V_FP      = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BP      = 33;
    localparam int c_V_TOTAL   = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;   // 525

    localparam int c_FB_ADDR_W = 19;

    localparam logic [7:0] c_COLOUR_WHITE = 8'hFF;
    localparam logic [7:0] c_COLOUR_BLACK = 8'h00;

    // Every field is active-high, so an all-zero bundle means "blanked, no
    // sync, no frame start". A cleared delay line therefore already shows
    // the idle output state.
    typedef struct packed {
        logic hs_act;   // horizontal sync pulse in progress
        logic vs_act;   // vertical sync pulse in progress
        logic h_vis;    // inside the visible part of the line
        logic v_vis;    // inside the visible lines of the frame
        logic de;       // visible pixel
        logic fs;       // first pixel of a frame
    } scan_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/fb_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : fb_delay_line
// Description : Shift register of parameterised depth. It delays the
//               scan_ctrl bundle so the bundle lines up with the pixel that
//               comes back from the framebuffer.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset; clears every stage
//               i_d     - bundle entering the line
//               o_q     - bundle delayed by DEPTH clocks
//               o_q_pre - bundle delayed by DEPTH-1 clocks (the tap just
//                         before the output, used to qualify the pixel
//                         register)
// Parameters  : WIDTH - bundle width; DEPTH - number of stages, at least 2
// Revision    : 1.0 - initial release
// ============================================================================
module fb_delay_line #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_pre
);

    // Stage 0 sits in the least significant WIDTH bits.
    logic [DEPTH*WIDTH-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[(DEPTH-1)*WIDTH-1:0], i_d};
        end
    end

    assign o_q     = r_chain[DEPTH*WIDTH-1     -: WIDTH];
    assign o_q_pre = r_chain[(DEPTH-1)*WIDTH-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// Module      : fb_scanout
// Description : VGA-style raster generator that scans a grey framebuffer.
//               It issues one read per visible pixel. All sync, blank and
//               frame_start outputs are delayed by RD_LATENCY+1 clocks so
//               they stay aligned with the registered pixel.
// Ports       : clk_pixel   - pixel clock; all logic is on its rising edge
//               reset       - synchronous active-high reset
//               en          - scanout request; a frame in progress completes
//               fb_rd_en    - framebuffer read strobe
//               fb_rd_addr  - framebuffer pixel address
//               fb_rd_data  - grey pixel, RD_LATENCY clocks after fb_rd_en
//               hs, vs      - sync outputs, active-low
//               r, g, b     - pixel colour (grey: all three are equal)
//               VGA_HB, VGA_VB, VGA_DE - blanking and data enable
//               frame_start - one-clock pulse with the first pixel of a frame
// Options     : FB_SCANOUT_SCALE2_EN - show a 320x240 source as 2x2 blocks
//               (H_ACTIVE must be even)
// Revision    : 1.0 - initial release
// ============================================================================
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int H_ACTIVE   = c_H_ACTIVE,
    parameter int H_FP       = c_H_FP,
    parameter int H_SYNC     = c_H_SYNC,
    parameter int H_BP       = c_H_BP,
    parameter int V_ACTIVE   = c_V_ACTIVE,
    parameter int V_FP       = c_V_FP,
    parameter int V_SYNC     = c_V_SYNC,
    parameter int V_BP       = c_V_BP,
    parameter int RD_LATENCY = 2
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   en,
    output logic                   fb_rd_en,
    output logic [c_FB_ADDR_W-1:0] fb_rd_addr,
    input  logic [7:0]             fb_rd_data,
    output logic                   hs,
    output logic                   vs,
    output logic [7:0]             r,
    output logic [7:0]             g,
    output logic [7:0]             b,
    output logic                   VGA_HB,
    output logic                   VGA_VB,
    output logic                   VGA_DE,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] c_H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] c_H_ACT      = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] c_H_ACT_LAST = H_W'(H_ACTIVE - 1);
    localparam logic [H_W-1:0] c_HS_FIRST   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] c_HS_LAST    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] c_V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] c_V_ACT      = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] c_V_ACT_LAST = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0] c_VS_FIRST   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] c_VS_LAST    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]             r_state;
    logic [H_W-1:0]         r_h_cnt;
    logic [V_W-1:0]         r_v_cnt;
    logic [c_FB_ADDR_W-1:0] r_addr;
    logic [7:0]             r_pixel;

    logic       w_run;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_active;
    logic       w_last_px;
    logic       w_step;
    scan_ctrl_t w_ctrl;
    scan_ctrl_t w_ctrl_q;
    scan_ctrl_t w_ctrl_pre;

    assign w_run     = (r_state == S_RUN);
    assign w_h_wrap  = (r_h_cnt == c_H_LAST);
    assign w_v_wrap  = (r_v_cnt == c_V_LAST);
    assign w_active  = w_run && (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign w_last_px = (r_h_cnt == c_H_ACT_LAST) && (r_v_cnt == c_V_ACT_LAST);

    // ------------------------------------------------------------------
    // Raster counters and run/idle control
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            if (en) begin
                r_state <= S_RUN;
            end
        end else begin
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                if (w_v_wrap) begin
                    r_v_cnt <= '0;
                    // Only stop at the frame boundary. If en drops earlier,
                    // the current frame still completes.
                    if (!en) begin
                        r_state <= S_IDLE;
                    end
                end else begin
                    r_v_cnt <= r_v_cnt + 1'b1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Incremental pixel address. The counter wraps to 0 at the last visible
    // pixel, so it always holds the address of the next pixel to fetch and
    // never goes past the end of the framebuffer.
    // ------------------------------------------------------------------
`ifdef FB_SCANOUT_SCALE2_EN
    localparam logic [c_FB_ADDR_W-1:0] c_REWIND = c_FB_ADDR_W'(H_ACTIVE / 2 - 1);
    // Each source pixel covers two columns, so the address moves on odd h.
    assign w_step = w_active && r_h_cnt[0];
`else
    assign w_step = w_active;
`endif

    always_ff @(posedge clk_pixel) begin
        if (reset || !w_run) begin
            r_addr <= '0;
        end else if (w_step) begin
            if (w_last_px) begin
                r_addr <= '0;
`ifdef FB_SCANOUT_SCALE2_EN
            end else if (!r_v_cnt[0] && (r_h_cnt == c_H_ACT_LAST)) begin
                // End of an even line: rewind so the odd line repeats the
                // same source row.
                r_addr <= r_addr - c_REWIND;
`endif
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign fb_rd_en   = w_active;
    assign fb_rd_addr = r_addr;

    // ------------------------------------------------------------------
    // Control bundle at counter time, then delayed RD_LATENCY+1 clocks
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl        = '0;
        w_ctrl.hs_act = w_run && (r_h_cnt >= c_HS_FIRST) && (r_h_cnt <= c_HS_LAST);
        w_ctrl.vs_act = w_run && (r_v_cnt >= c_VS_FIRST) && (r_v_cnt <= c_VS_LAST);
        w_ctrl.h_vis  = w_run && (r_h_cnt < c_H_ACT);
        w_ctrl.v_vis  = w_run && (r_v_cnt < c_V_ACT);
        w_ctrl.de     = w_active;
        w_ctrl.fs     = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    fb_delay_line #(
        .WIDTH ($bits(scan_ctrl_t)),
        .DEPTH (RD_LATENCY + 1)
    ) u_delay (
        .clk     (clk_pixel),
        .rst     (reset),
        .i_d     (w_ctrl),
        .o_q     (w_ctrl_q),
        .o_q_pre (w_ctrl_pre)
    );

    // The tap before the output belongs to the pixel that fb_rd_data holds
    // now. Registering here makes that pixel leave together with w_ctrl_q.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_pixel <= c_COLOUR_BLACK;
        end else begin
            r_pixel <= w_ctrl_pre.de ? fb_rd_data : c_COLOUR_BLACK;
        end
    end

    assign r           = r_pixel;
    assign g           = r_pixel;
    assign b           = r_pixel;
    assign hs          = ~w_ctrl_q.hs_act;
    assign vs          = ~w_ctrl_q.vs_act;
    assign VGA_HB      = ~w_ctrl_q.h_vis;
    assign VGA_VB      = ~w_ctrl_q.v_vis;
    assign VGA_DE      = w_ctrl_q.de;
    assign frame_start = w_ctrl_q.fs;

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_scanout
// Description : Self-checking bench for fb_scanout. It uses a reduced raster
//               (80x56 total) so that whole frames run quickly. A frame-level
//               reference model is checked every cycle, and literal
//               expectations pin the model. Build with FB_SCANOUT_SCALE2_EN
//               to check the 2x2 build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_scanout;

    localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
    localparam int VA = 48, VFP = 2, VSW = 2, VBP = 4;
    localparam int LAT   = 3;
    localparam int HT    = HA + HFP + HSW + HBP;   // 80
    localparam int VT    = VA + VFP + VSW + VBP;   // 56
    localparam int FRAME = HT * VT;                // 4480

`ifdef FB_SCANOUT_SCALE2_EN
    localparam int PX1 = 0, PXROW1 = 0, LINE2 = 32, LASTADDR = 767;
`else
    localparam int PX1 = 1, PXROW1 = 64, LINE2 = 128, LASTADDR = 3071;
`endif

    logic        clk_pixel = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        fb_rd_en;
    logic [18:0] fb_rd_addr;
    logic [7:0]  fb_rd_data;
    logic        hs, vs, VGA_HB, VGA_VB, VGA_DE, frame_start;
    logic [7:0]  r, g, b;

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .RD_LATENCY(LAT)
    ) dut (
        .clk_pixel(clk_pixel), .reset(reset), .en(en),
        .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
        .VGA_HB(VGA_HB), .VGA_VB(VGA_VB), .VGA_DE(VGA_DE),
        .frame_start(frame_start)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Model RAM: the data returned is addr[7:0], LAT clocks after the read.
    // Cycles without a read return random junk.
    logic [7:0] mem_pipe [LAT];
    always @(posedge clk_pixel) begin
        mem_pipe[0] <= fb_rd_en ? fb_rd_addr[7:0] : 8'($urandom);
        for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign fb_rd_data = mem_pipe[LAT-1];

    // ------------------------------------------------------------------
    // Reference model: a running flag and a linear position in the frame.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic hs, vs, hb, vb, de, fs;
        logic [7:0] pix;
    } exp_t;

    bit   m_run  = 0;
    int   m_p    = 0;
    bit   chk_on = 0;
    exp_t hist [LAT+1];

    function automatic exp_t blank_exp();
        exp_t e;
        e = '0;
        e.hs = 1'b1; e.vs = 1'b1; e.hb = 1'b1; e.vb = 1'b1;
        return e;
    endfunction

    function automatic int pix_addr(int h, int v);
`ifdef FB_SCANOUT_SCALE2_EN
        return (v / 2) * (HA / 2) + h / 2;
`else
        return v * HA + h;
`endif
    endfunction

    function automatic bit m_rd();
        return m_run && (m_p % HT < HA) && (m_p / HT < VA);
    endfunction

    function automatic exp_t now_exp();
        exp_t e;
        int h, v;
        h = m_p % HT;
        v = m_p / HT;
        if (!m_run) return blank_exp();
        e.hs  = !(h >= HA + HFP && h < HA + HFP + HSW);
        e.vs  = !(v >= VA + VFP && v < VA + VFP + VSW);
        e.hb  = (h >= HA);
        e.vb  = (v >= VA);
        e.de  = !e.hb && !e.vb;
        e.fs  = (m_p == 0);
        e.pix = e.de ? 8'(pix_addr(h, v)) : 8'h00;
        return e;
    endfunction

    always @(posedge clk_pixel) begin
        exp_t cur;
        if (reset) begin
            for (int i = 0; i <= LAT; i++) hist[i] = blank_exp();
            m_run  = 0;
            m_p    = 0;
            chk_on = 1;
        end else begin
            cur = now_exp();
            for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = cur;
            if (!m_run) begin
                if (en) m_run = 1;
            end else begin
                m_p++;
                if (m_p == FRAME) begin
                    m_p = 0;
                    if (!en) m_run = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    int          rd_cnt   = 0;
    logic [18:0] max_addr = '0;

    always @(negedge clk_pixel) begin
        if (chk_on) begin
            check("rd_en", fb_rd_en, m_rd());
            if (m_rd()) check("rd_addr", fb_rd_addr, pix_addr(m_p % HT, m_p / HT));
            if (m_run && m_p == 2 * HT) check("line2_addr", fb_rd_addr, LINE2);
            check("ctrl", {hs, vs, VGA_HB, VGA_VB, VGA_DE, frame_start},
                  {hist[LAT].hs, hist[LAT].vs, hist[LAT].hb, hist[LAT].vb,
                   hist[LAT].de, hist[LAT].fs});
            check("pixel", {r, g, b}, {3{hist[LAT].pix}});
            if (fb_rd_en) begin
                rd_cnt++;
                if (fb_rd_addr > max_addr) max_addr = fb_rd_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence followed by random en/reset traffic
    // ------------------------------------------------------------------
    task automatic wait_pos(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (!(m_run && m_p == target) && i < budget) begin
            @(posedge clk_pixel); #2;
            i++;
        end
        check(name, (m_run && m_p == target), 1);
    endtask

    initial begin
        int de_n, hs_lo, vs_lo, fs_n, last_fall, vs_fall, i;
        bit found, prev_hs, prev_vs;

        // Reset for 3 clocks, then release with en low.
        reset = 1; en = 0;
        repeat (3) @(posedge clk_pixel);
        #2 reset = 0;
        @(negedge clk_pixel);
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_rgb", {r, g, b}, 0);
        check("rst_hb", VGA_HB, 1);
        check("rst_vb", VGA_VB, 1);
        check("rst_de", VGA_DE, 0);
        check("rst_fs", frame_start, 0);
        rd_cnt = 0;
        repeat (1000) @(posedge clk_pixel);
        #2 check("idle_reads", rd_cnt, 0);

        // Free-running frame with frame-level measurements.
        en = 1;
        found = 0;
        for (int k = 0; k < FRAME + 50 && !found; k++) begin
            @(negedge clk_pixel);
            if (frame_start) found = 1;
        end
        check("fs_seen", found, 1);
        de_n = 0; hs_lo = 0; vs_lo = 0; fs_n = 0; last_fall = -1; vs_fall = -1;
        prev_hs = 1; prev_vs = 1;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk_pixel);
            if (VGA_DE) begin
                if (de_n == 0)           check("de_px0", r, 0);
                if (de_n == 1)           check("de_px1", r, PX1);
                if (de_n == HA)          check("de_px_row1", r, PXROW1);
                if (de_n == HA * VA - 1) check("de_px_last", r, 8'hFF);
                de_n++;
            end
            if (!hs) hs_lo++;
            if (!vs) vs_lo++;
            if (frame_start) fs_n++;
            if (prev_hs && !hs) begin
                if (last_fall < 0) check("hs_first_fall", c, HA + HFP);
                else               check("hs_period", c - last_fall, HT);
                last_fall = c;
            end
            if (prev_vs && !vs) vs_fall = c;
            prev_hs = hs;
            prev_vs = vs;
        end
        @(negedge clk_pixel);
        check("fs_period", frame_start, 1);
        check("de_count", de_n, HA * VA);
        check("hs_low_count", hs_lo, HSW * VT);
        check("vs_low_count", vs_lo, VSW * HT);
        check("fs_count", fs_n, 1);
        check("vs_fall_ofs", vs_fall, (VA + VFP) * HT);

        // Drop en at the start of line 10: the frame must still complete.
        wait_pos(10 * HT, 2 * FRAME, "reach_v10");
        en = 0;
        rd_cnt = 0;
        i = 0;
        while (m_run && i < 2 * FRAME) begin
            @(posedge clk_pixel); #2;
            i++;
        end
        check("frame_finished", m_run, 0);
        repeat (FRAME) @(posedge clk_pixel);
        #2 check("drop_reads", rd_cnt, (VA - 10) * HA);

        // Reset mid-frame while the aligned hs would be low.
        en = 1;
        wait_pos(20 * HT + 72, 2 * FRAME, "reach_v20");
        reset = 1;
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        check("midrst_rd_en", fb_rd_en, 0);
        check("midrst_hs", hs, 1);
        reset = 0;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk_pixel);
            if (fb_rd_en) found = 1;
        end
        check("restart_read", found, 1);
        check("restart_addr", fb_rd_addr, 0);
        repeat (FRAME) @(posedge clk_pixel);

        // Random en toggling with occasional resets.
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk_pixel); #2;
            if ($urandom_range(0, 599) == 0) en = ~en;
            reset = ($urandom_range(0, 2999) == 0);
        end
        reset = 0;
        repeat (LAT + 4) @(posedge clk_pixel);

        check("max_addr", max_addr, LASTADDR);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
